uart_sd_sector_packer: RTL

//  Byte-stream to SD-sector bridge between the UART receiver and the SD card write controller.

---
 rtl/uart_sd_sector_packer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_sd_sector_packer.sv
// uart_sd_sector_packer: packs a UART byte stream into SD sectors held in a
// ring of NUM_BUFS buffers, requests one write per committed sector and serves
// the writer's word reads (first byte of each word in the MSBs).
// Optional feature macro: IDLE_FLUSH_EN (idle timeout flushes a partial sector).
module uart_sd_sector_packer #(
    parameter int          OUT_W        = 16,
    parameter int          SECTOR_BYTES = 512,
    parameter int          NUM_BUFS     = 2,
    parameter logic [31:0] START_ADDR   = 32'd0,
    parameter int          IDLE_CYCLES  = 500000,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          wr_req,
    output logic [31:0]                   wr_addr,
    input  logic                          wr_ack,
    input  logic                          wr_data_req,
    output logic [OUT_W-1:0]              wr_data,
    input  logic                          wr_done,
    output logic                          overflow,
    output logic [$clog2(NUM_BUFS):0]     buf_level,
    output logic [31:0]                   sectors_written
);
    localparam int B     = OUT_W / 8;
    localparam int WORDS = SECTOR_BYTES / B;
    localparam int PTR_W = $clog2(NUM_BUFS);
    localparam int BC_W  = $clog2(SECTOR_BYTES);
    localparam int OFF_W = BC_W + 1;
    localparam int WI_W  = $clog2(WORDS) + 1;
    localparam int LVL_W = $clog2(NUM_BUFS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    logic [7:0]       mem [NUM_BUFS*SECTOR_BYTES];
    logic [OFF_W-1:0] len [NUM_BUFS];
    logic [PTR_W-1:0] fill_ptr, drain_ptr, fill_ptr_nxt, wr_buf;
    logic [BC_W-1:0]  byte_cnt, byte_cnt_nxt, wr_off;
    logic [OFF_W-1:0] commit_len, off;
    logic [WI_W-1:0]  word_idx;
    logic [OUT_W-1:0] word;
    logic             full, wr_en, commit, drop, release_buf, flush;
    state_t           state, state_nxt;

    assign full        = (buf_level == LVL_W'(NUM_BUFS));
    assign release_buf = (state == S_XFER) && wr_done;
    assign wr_req      = (state == S_REQ);

`ifdef IDLE_FLUSH_EN
    logic [31:0] idle_cnt;

    // Idle timer: runs while a partial sector sits untouched, saturates at the timeout
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                                    idle_cnt <= '0;
        else if (in_valid || flush)                     idle_cnt <= '0;
        else if (byte_cnt != '0 && idle_cnt != 32'(IDLE_CYCLES)) idle_cnt <= idle_cnt + 32'd1;
    end

    assign flush = (idle_cnt == 32'(IDLE_CYCLES)) && (byte_cnt != '0) && !full;
`else
    assign flush = 1'b0;
`endif

    // Fill-side decisions: where the incoming byte lands and whether a buffer commits
    always_comb begin
        wr_en        = 1'b0;
        wr_buf       = fill_ptr;
        wr_off       = byte_cnt;
        commit       = 1'b0;
        commit_len   = OFF_W'(SECTOR_BYTES);
        byte_cnt_nxt = byte_cnt;
        fill_ptr_nxt = fill_ptr;
        drop         = 1'b0;
        if (flush) begin
            // Partial commit; a byte arriving now starts the following buffer
            commit       = 1'b1;
            commit_len   = {1'b0, byte_cnt};
            fill_ptr_nxt = fill_ptr + 1'b1;
            byte_cnt_nxt = '0;
            if (in_valid) begin
                if (buf_level < LVL_W'(NUM_BUFS - 1)) begin
                    wr_en        = 1'b1;
                    wr_buf       = fill_ptr + 1'b1;
                    wr_off       = '0;
                    byte_cnt_nxt = BC_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end else if (in_valid) begin
            if (full) begin
                drop = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (byte_cnt == BC_W'(SECTOR_BYTES - 1)) begin
                    commit       = 1'b1;
                    byte_cnt_nxt = '0;
                    fill_ptr_nxt = fill_ptr + 1'b1;
                end else begin
                    byte_cnt_nxt = byte_cnt + 1'b1;
                end
            end
        end
    end

    // Sector storage; contents need no reset since lengths gate what is read
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[{wr_buf, wr_off}] <= in_data;
    end

    // Fill pointer, byte count, committed lengths and sticky overflow
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fill_ptr <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_BUFS; i++) len[i] <= OFF_W'(SECTOR_BYTES);
        end else begin
            fill_ptr <= fill_ptr_nxt;
            byte_cnt <= byte_cnt_nxt;
            if (drop)   overflow      <= 1'b1;
            if (commit) len[fill_ptr] <= commit_len;
        end
    end

    // Level of committed sectors; simultaneous commit and release cancel
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                     buf_level <= '0;
        else if (commit && !release_buf) buf_level <= buf_level + 1'b1;
        else if (!commit && release_buf) buf_level <= buf_level - 1'b1;
    end

    // Drain FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Drain FSM next state: request, wait for ack, transfer until done
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (buf_level != '0) state_nxt = S_REQ;
            S_REQ:   if (wr_ack)          state_nxt = S_XFER;
            S_XFER:  if (wr_done)         state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Assemble the word at word_idx; past the sector or past stored length reads PAD_BYTE
    always_comb begin
        word = '0;
        off  = '0;
        for (int j = 0; j < B; j++) begin
            off = OFF_W'(word_idx) * OFF_W'(B) + OFF_W'(j);
            if (word_idx < WI_W'(WORDS) && off < len[drain_ptr])
                word[OUT_W-1-8*j -: 8] = mem[{drain_ptr, off[BC_W-1:0]}];
            else
                word[OUT_W-1-8*j -: 8] = PAD_BYTE;
        end
    end

    // Drain side: word reads, buffer release, address and completion count
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drain_ptr       <= '0;
            wr_addr         <= START_ADDR;
            sectors_written <= '0;
            word_idx        <= '0;
            wr_data         <= '0;
        end else begin
            if (state == S_REQ && wr_ack) word_idx <= '0;
            if (state == S_XFER && wr_data_req) begin
                wr_data <= word;
                if (word_idx != WI_W'(WORDS)) word_idx <= word_idx + 1'b1;
            end
            if (release_buf) begin
                drain_ptr       <= drain_ptr + 1'b1;
                wr_addr         <= wr_addr + 32'd1;
                sectors_written <= sectors_written + 32'd1;
            end
        end
    end
endmodule
